// File: rtl/tlb_refill_walker.sv
// Two-level page-table walker that refills a small TLB on a miss.
// Single outstanding PTE read; round-robin victim on a successful fill, fault report otherwise.
module tlb_refill_walker #(
  parameter int ENTRY_NUM         = 16,
  parameter int VPN_WIDTH         = 20,
  parameter int PPN_WIDTH         = 20,
  parameter int PAGE_OFFSET_WIDTH = 12
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 miss_valid_i,
  output logic                                 miss_ready_o,
  input  logic [VPN_WIDTH-1:0]                 miss_vpn_i,
  input  logic [PPN_WIDTH-1:0]                 pt_base_ppn_i,
  output logic                                 mem_req_valid_o,
  input  logic                                 mem_req_ready_i,
  output logic [PPN_WIDTH+PAGE_OFFSET_WIDTH-1:0] mem_req_addr_o,
  input  logic                                 mem_resp_valid_i,
  input  logic [PPN_WIDTH+PAGE_OFFSET_WIDTH-1:0] mem_resp_data_i,
  output logic                                 write_en_o,
  output logic [$clog2(ENTRY_NUM)-1:0]         write_index_o,
  output logic [VPN_WIDTH-1:0]                 write_vpn_o,
  output logic [PPN_WIDTH-1:0]                 write_ppn_o,
  output logic                                 done_valid_o,
  output logic                                 done_fault_o
);

  // state   | meaning
  // IDLE    | ready for a miss
  // REQ_L1  | root-level PTE read offered to memory
  // WAIT_L1 | waiting for root-level PTE
  // REQ_L0  | leaf-level PTE read offered to memory
  // WAIT_L0 | waiting for leaf-level PTE
  // FILL    | one-cycle TLB write, done without fault
  // FAULT   | one-cycle done with fault
  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int LVL   = VPN_WIDTH / 2;
  localparam int PTE_W = PPN_WIDTH + PAGE_OFFSET_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRY_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_L1  = 3'd1,
    S_WAIT_L1 = 3'd2,
    S_REQ_L0  = 3'd3,
    S_WAIT_L0 = 3'd4,
    S_FILL    = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [VPN_WIDTH-1:0] vpn_q, vpn_d;
  logic [PPN_WIDTH-1:0] base_q, base_d;
  logic [PPN_WIDTH-1:0] ppn_q, ppn_d;
  logic [IDX_W-1:0]     victim_q, victim_d;

  logic                 pte_v;
  logic                 pte_l;
  logic [PPN_WIDTH-1:0] pte_ppn;
  logic                 pte_unused;

  assign pte_v      = mem_resp_data_i[0];
  assign pte_l      = mem_resp_data_i[1];
  assign pte_ppn    = mem_resp_data_i[PTE_W-1 -: PPN_WIDTH];
  assign pte_unused = ^mem_resp_data_i[PAGE_OFFSET_WIDTH-1:2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      vpn_q    <= '0;
      base_q   <= '0;
      ppn_q    <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      vpn_q    <= vpn_d;
      base_q   <= base_d;
      ppn_q    <= ppn_d;
      victim_q <= victim_d;
    end
  end

  // base_q holds the root PPN for the first read and is reused for the leaf table base
  always_comb begin
    state_d  = state_q;
    vpn_d    = vpn_q;
    base_d   = base_q;
    ppn_d    = ppn_q;
    victim_d = victim_q;
    unique case (state_q)
      S_IDLE: begin
        if (miss_valid_i) begin
          vpn_d   = miss_vpn_i;
          base_d  = pt_base_ppn_i;
          state_d = S_REQ_L1;
        end
      end
      S_REQ_L1: if (mem_req_ready_i) state_d = S_WAIT_L1;
      S_WAIT_L1: begin
        if (mem_resp_valid_i) begin
          if (!pte_v) begin
            state_d = S_FAULT;
          end else if (pte_l) begin
            if (pte_ppn[LVL-1:0] != '0) begin
              state_d = S_FAULT;
            end else begin
              ppn_d   = {pte_ppn[PPN_WIDTH-1:LVL], vpn_q[LVL-1:0]};
              state_d = S_FILL;
            end
          end else begin
            base_d  = pte_ppn;
            state_d = S_REQ_L0;
          end
        end
      end
      S_REQ_L0: if (mem_req_ready_i) state_d = S_WAIT_L0;
      S_WAIT_L0: begin
        if (mem_resp_valid_i) begin
          if (!pte_v || !pte_l) begin
            state_d = S_FAULT;
          end else begin
            ppn_d   = pte_ppn;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        victim_d = (victim_q == LAST_IDX) ? '0 : victim_q + IDX_W'(1);
        state_d  = S_IDLE;
      end
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    write_en_o      = 1'b0;
    done_valid_o    = 1'b0;
    done_fault_o    = 1'b0;
    unique case (state_q)
      S_IDLE:   miss_ready_o = 1'b1;
      S_REQ_L1,
      S_REQ_L0: mem_req_valid_o = 1'b1;
      S_FILL: begin
        write_en_o   = 1'b1;
        done_valid_o = 1'b1;
      end
      S_FAULT: begin
        done_valid_o = 1'b1;
        done_fault_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_req_addr_o = (state_q == S_REQ_L0) ? {base_q, vpn_q[LVL-1:0], 2'b00}
                                                : {base_q, vpn_q[VPN_WIDTH-1:LVL], 2'b00};
  assign write_index_o  = victim_q;
  assign write_vpn_o    = vpn_q;
  assign write_ppn_o    = ppn_q;

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Self-checking bench for tlb_refill_walker: vector table of walks, a scoreboard of
// expected completions, and hand-written backpressure / reset / spurious-response sequences.
module tb_tlb_refill_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid;
  logic        miss_ready;
  logic [19:0] miss_vpn;
  logic [19:0] pt_base;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        write_en;
  logic [3:0]  write_index;
  logic [19:0] write_vpn;
  logic [19:0] write_ppn;
  logic        done_valid;
  logic        done_fault;

  tlb_refill_walker dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .miss_valid_i    (miss_valid),
    .miss_ready_o    (miss_ready),
    .miss_vpn_i      (miss_vpn),
    .pt_base_ppn_i   (pt_base),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_addr_o  (mem_req_addr),
    .mem_resp_valid_i(mem_resp_valid),
    .mem_resp_data_i (mem_resp_data),
    .write_en_o      (write_en),
    .write_index_o   (write_index),
    .write_vpn_o     (write_vpn),
    .write_ppn_o     (write_ppn),
    .done_valid_o    (done_valid),
    .done_fault_o    (done_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] vpn;
    logic [19:0] base;
    logic [31:0] pte1;
    logic [31:0] pte2;
    logic [31:0] addr1;
    logic [31:0] addr2;
    int          nreads;
    bit          fault;
    logic [19:0] ppn;
    int          lat;
  } vec_t;

  typedef struct {
    bit          fault;
    logic [3:0]  idx;
    logic [19:0] vpn;
    logic [19:0] ppn;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] victim_m;
  vec_t       vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic walk(input vec_t v, input int rdy, input int rsp);
    int          t0;
    int          n;
    bit          busy_ok;
    bit          hold_ok;
    bit          idle_ok;
    bit          extra;
    logic [31:0] ea;
    exp_t        e;
    exp_t        g;
    n = 0;
    while (!miss_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("miss_ready_before_walk", miss_ready, 1);
    miss_valid = 1'b1;
    miss_vpn   = v.vpn;
    pt_base    = v.base;
    t0         = cyc;
    e.fault = v.fault;
    e.idx   = victim_m;
    e.vpn   = v.vpn;
    e.ppn   = v.ppn;
    sb.push_back(e);
    if (!v.fault) victim_m = victim_m + 4'd1;
    @(negedge clk);
    miss_valid = 1'b0;
    busy_ok = 1'b1;
    extra   = 1'b0;
    for (int lvl = 0; lvl < v.nreads; lvl++) begin
      ea = (lvl == 0) ? v.addr1 : v.addr2;
      n = 0;
      while (!mem_req_valid && n < 50) begin
        busy_ok &= !miss_ready;
        @(negedge clk);
        n++;
      end
      check("req_valid", mem_req_valid, 1);
      check("req_addr", mem_req_addr, ea);
      hold_ok = 1'b1;
      for (int k = 0; k < rdy; k++) begin
        busy_ok &= !miss_ready;
        @(negedge clk);
        hold_ok &= mem_req_valid && (mem_req_addr == ea);
      end
      if (rdy > 0) check("req_hold_stable", hold_ok, 1);
      busy_ok &= !miss_ready;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      idle_ok = 1'b1;
      for (int k = 0; k < rsp; k++) begin
        busy_ok &= !miss_ready;
        idle_ok &= !mem_req_valid && !done_valid;
        @(negedge clk);
      end
      if (rsp > 0) check("quiet_while_waiting", idle_ok, 1);
      busy_ok &= !miss_ready;
      mem_resp_valid = 1'b1;
      mem_resp_data  = (lvl == 0) ? v.pte1 : v.pte2;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'hDEADBEEF;
    end
    n = 0;
    while (!done_valid && n < 50) begin
      busy_ok &= !miss_ready;
      if (mem_req_valid) extra = 1'b1;
      @(negedge clk);
      n++;
    end
    check("done_valid", done_valid, 1);
    check("done_latency", cyc - t0, v.lat + v.nreads * (rdy + rsp));
    check("miss_ready_low_in_walk", busy_ok, 1);
    check("no_extra_read", extra, 0);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got completion expected none");
    end else begin
      g = sb.pop_front();
      check("done_fault", done_fault, g.fault);
      check("write_en", write_en, !g.fault);
      if (!g.fault) begin
        check("write_index", write_index, g.idx);
        check("write_vpn", write_vpn, g.vpn);
        check("write_ppn", write_ppn, g.ppn);
      end
    end
    @(negedge clk);
    check("done_one_cycle", done_valid, 0);
    check("write_en_one_cycle", write_en, 0);
    check("miss_ready_after", miss_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = '{20'h12345, 20'h80000, 32'h00081001, 32'hABCDE003, 32'h80000120, 32'h00081D14, 2, 0, 20'hABCDE, 5};
    vecs[1] = '{20'h00402, 20'h80000, 32'h40000003, 32'h0,        32'h80000004, 32'h0,        1, 0, 20'h40002, 3};
    vecs[2] = '{20'h12345, 20'h80000, 32'h00000000, 32'h0,        32'h80000120, 32'h0,        1, 1, 20'h0,     3};
    vecs[3] = '{20'h12345, 20'h80000, 32'h00081001, 32'h12345001, 32'h80000120, 32'h00081D14, 2, 1, 20'h0,     5};
    vecs[4] = '{20'h00402, 20'h80000, 32'h40001003, 32'h0,        32'h80000004, 32'h0,        1, 1, 20'h0,     3};
    vecs[5] = '{20'hFFFFF, 20'h00001, 32'h77777001, 32'h13579C03, 32'h00001FFC, 32'h77777FFC, 2, 0, 20'h13579, 5};
    vecs[6] = '{20'hFFD55, 20'h12345, 32'hFFC00003, 32'h0,        32'h12345FFC, 32'h0,        1, 0, 20'hFFD55, 3};
    vecs[7] = '{20'h00402, 20'h80000, 32'h00081002, 32'h0,        32'h80000004, 32'h0,        1, 1, 20'h0,     3};
    vecs[8] = '{20'h12345, 20'h80000, 32'h00081001, 32'hABCDE002, 32'h80000120, 32'h00081D14, 2, 1, 20'h0,     5};

    rst            = 1'b1;
    miss_valid     = 1'b0;
    miss_vpn       = '0;
    pt_base        = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'hDEADBEEF;
    @(negedge clk);
    check("rst_miss_ready", miss_ready, 1);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_write_en", write_en, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_fault", done_fault, 0);
    @(negedge clk);
    rst = 1'b0;
    victim_m = 4'd0;

    for (int i = 0; i < 9; i++) walk(vecs[i], 0, 0);

    // backpressure on both levels
    walk(vecs[0], 3, 4);

    // response while idle must be ignored
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hABCDE003;
    @(negedge clk);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("spurious_miss_ready", miss_ready, 1);
    check("spurious_req_valid", mem_req_valid, 0);
    check("spurious_done", done_valid, 0);
    check("spurious_write", write_en, 0);
    walk(vecs[1], 0, 0);

    // reset in WAIT_L0, then a late response
    miss_valid = 1'b1;
    miss_vpn   = 20'h12345;
    pt_base    = 20'h80000;
    @(negedge clk);
    miss_valid    = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h00081001;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("rstwalk_req_l0", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("rstwalk_wait_l0_busy", miss_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_miss_ready", miss_ready, 1);
    check("midrst_write_en", write_en, 0);
    check("midrst_done", done_valid, 0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hABCDE003;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("late_resp_write_en", write_en, 0);
    check("late_resp_done", done_valid, 0);
    check("late_resp_req", mem_req_valid, 0);
    victim_m = 4'd0;

    // 17 back-to-back fills: index must run 0..15 then wrap to 0
    for (int i = 0; i < 17; i++) begin
      v.vpn    = {10'(i + 1), 10'(i * 37)};
      v.base   = 20'h80000 + 20'(i);
      v.pte1   = {20'h10000 + 20'(i), 12'h001};
      v.pte2   = {20'hA0000 + 20'(i * 3), 12'h003};
      v.addr1  = {v.base, v.vpn[19:10], 2'b00};
      v.addr2  = {v.pte1[31:12], v.vpn[9:0], 2'b00};
      v.nreads = 2;
      v.fault  = 1'b0;
      v.ppn    = v.pte2[31:12];
      v.lat    = 5;
      walk(v, 0, 0);
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
